// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that shares one radix-4 Booth multiplier core among N_REQ requesters.
// Each operation has a watchdog timeout, and each result is returned through a valid/ready response port.
module booth_mul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH_M = 8,
   parameter int WIDTH_R = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [N_REQ-1:0]             req_vld,
   output logic [N_REQ-1:0]             req_rdy,
   input  logic [N_REQ*WIDTH_M-1:0]     req_a,
   input  logic [N_REQ*WIDTH_R-1:0]     req_b,
   output logic                         rsp_vld,
   input  logic                         rsp_rdy,
   output logic [$clog2(N_REQ)-1:0]     rsp_id,
   output logic [WIDTH_M+WIDTH_R-1:0]   rsp_data,
   output logic                         rsp_err,
   output logic                         mul_vld,
   output logic [WIDTH_M-1:0]           mul_a,
   output logic [WIDTH_R-1:0]           mul_b,
   input  logic [WIDTH_M+WIDTH_R-1:0]   mul_p,
   input  logic                         mul_done,
   output logic                         busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int P_W   = WIDTH_M + WIDTH_R;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ID_W:0]    N_REQ_V = (ID_W+1)'(N_REQ);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t             state_reg, state_next;
   logic [ID_W-1:0]    last_grant_reg, last_grant_next;
   logic [ID_W-1:0]    rsp_id_reg, rsp_id_next;
   logic [P_W-1:0]     rsp_data_reg, rsp_data_next;
   logic               rsp_err_reg, rsp_err_next;
   logic [WIDTH_M-1:0] mul_a_reg, mul_a_next;
   logic [WIDTH_R-1:0] mul_b_reg, mul_b_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;

   logic [ID_W-1:0]    cand_idx [N_REQ];
   logic [N_REQ-1:0]   cand_vld;
   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;

   // Candidate gi is the requester at distance gi+1 from the last grant.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum          = {1'b0, last_grant_reg} + (ID_W+1)'(gi + 1);
      assign cand_idx[gi] = ID_W'((sum >= N_REQ_V) ? sum - N_REQ_V : sum);
      assign cand_vld[gi] = req_vld[cand_idx[gi]];
   end

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand_vld[i]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx[i];
         end
      end
   end

   always_comb begin
      req_rdy = '0;
      if (rstn && state_reg == IDLE && grant_found)
         req_rdy[grant_idx] = 1'b1;
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      rsp_id_next     = rsp_id_reg;
      rsp_data_next   = rsp_data_reg;
      rsp_err_next    = rsp_err_reg;
      mul_a_next      = mul_a_reg;
      mul_b_next      = mul_b_reg;
      cnt_next        = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               mul_a_next      = req_a[grant_idx*WIDTH_M +: WIDTH_M];
               mul_b_next      = req_b[grant_idx*WIDTH_R +: WIDTH_R];
               rsp_id_next     = grant_idx;
               last_grant_next = grant_idx;
               cnt_next        = '0;
               state_next      = BUSY;
            end
         end
         BUSY: begin
            cnt_next = cnt_reg + 1'b1;
            // A completion on the final watchdog cycle still counts as success.
            if (mul_done) begin
               rsp_data_next = mul_p;
               rsp_err_next  = 1'b0;
               state_next    = RESP;
            end else if (cnt_reg == TO_LAST) begin
               rsp_data_next = '0;
               rsp_err_next  = 1'b1;
               state_next    = RESP;
            end
         end
         RESP: begin
            if (rsp_rdy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         last_grant_reg <= ID_W'(N_REQ - 1);
         rsp_id_reg     <= '0;
         rsp_data_reg   <= '0;
         rsp_err_reg    <= 1'b0;
         mul_a_reg      <= '0;
         mul_b_reg      <= '0;
         cnt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         rsp_id_reg     <= rsp_id_next;
         rsp_data_reg   <= rsp_data_next;
         rsp_err_reg    <= rsp_err_next;
         mul_a_reg      <= mul_a_next;
         mul_b_reg      <= mul_b_next;
         cnt_reg        <= cnt_next;
      end
   end

   assign rsp_vld  = (state_reg == RESP);
   assign mul_vld  = (state_reg == BUSY);
   assign busy     = (state_reg != IDLE);
   assign rsp_id   = rsp_id_reg;
   assign rsp_data = rsp_data_reg;
   assign rsp_err  = rsp_err_reg;
   assign mul_a    = mul_a_reg;
   assign mul_b    = mul_b_reg;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: table of single operations plus contention,
// backpressure and reset-during-operation sequences against a behavioural multiplier core.
module tb_booth_mul_arbiter;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_vld;
   logic [3:0]  req_rdy;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        mul_vld;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;
   logic        mul_done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Behavioural core: product after core_lat BUSY cycles, or never when core_en is low.
   int   core_lat = 2;
   logic core_en  = 1'b1;
   int   core_cnt = 0;
   logic signed [15:0] sa, sb;

   assign sa       = {{8{mul_a[7]}}, mul_a};
   assign sb       = {{8{mul_b[7]}}, mul_b};
   assign mul_p    = sa * sb;
   assign mul_done = mul_vld && core_en && (core_cnt == core_lat - 1);

   always @(posedge clk) begin
      if (!mul_vld) core_cnt <= 0;
      else          core_cnt <= core_cnt + 1;
   end

   booth_mul_arbiter #(.N_REQ(4), .WIDTH_M(8), .WIDTH_R(8), .TIMEOUT(64)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req_vld  (req_vld),
      .req_rdy  (req_rdy),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_vld  (rsp_vld),
      .rsp_rdy  (rsp_rdy),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .mul_vld  (mul_vld),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_p    (mul_p),
      .mul_done (mul_done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      int          id;
      logic [7:0]  a;
      logic [7:0]  b;
      int          lat;
      logic [15:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_grant(input int id);
      int n = 0;
      #1;
      while (req_rdy == 4'b0 && n < 100) begin
         tick();
         n++;
      end
      chk("grant", {28'b0, req_rdy}, 32'(1 << id));
   endtask

   // Caller is in the first BUSY cycle; cyc returns the cycle index of rsp_vld counted from the grant cycle.
   task automatic wait_rsp(output int cyc);
      cyc = 1;
      while (!rsp_vld && cyc < 300) begin
         tick();
         cyc++;
      end
      chk("rsp_arrives", {31'b0, rsp_vld}, 32'd1);
   endtask

   task automatic run_op(input vec_t v);
      int lat;
      core_lat = v.lat;
      core_en  = (v.lat > 0);
      req_a[v.id*8 +: 8] = v.a;
      req_b[v.id*8 +: 8] = v.b;
      rsp_rdy = 1'b1;
      req_vld = 4'(1 << v.id);
      wait_grant(v.id);
      tick();
      req_vld = 4'b0;
      #1;
      chk("mul_vld_busy", {31'b0, mul_vld}, 32'd1);
      chk("mul_operands", {16'b0, mul_a, mul_b}, {16'b0, v.a, v.b});
      wait_rsp(lat);
      chk("latency", lat, v.exp_lat);
      chk("rsp_id", {30'b0, rsp_id}, v.id);
      chk("rsp_data", {16'b0, rsp_data}, {16'b0, v.exp_data});
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
      $display("op id=%0d a=%h b=%h data=%h err=%b lat=%0d", v.id, v.a, v.b, rsp_data, rsp_err, lat);
      tick();
      chk("rsp_vld_falls", {31'b0, rsp_vld}, 32'd0);
   endtask

   initial begin
      int k, n, lat;
      logic seen;

      //           id  a      b      lat exp_data  err exp_lat
      vecs[0] = '{2, 8'h07, 8'hFD, 3,  16'hFFEB, 0, 4};
      vecs[1] = '{0, 8'h80, 8'h80, 4,  16'h4000, 0, 5};
      vecs[2] = '{1, 8'h7F, 8'h80, 1,  16'hC080, 0, 2};
      vecs[3] = '{3, 8'hFF, 8'hFF, 2,  16'h0001, 0, 3};
      vecs[4] = '{0, 8'h00, 8'h5A, 5,  16'h0000, 0, 6};
      vecs[5] = '{1, 8'h7F, 8'h7F, 3,  16'h3F01, 0, 4};
      // Watchdog abort: rsp_vld arrives on the 64th edge after the grant edge.
      vecs[6] = '{3, 8'h12, 8'h34, 0,  16'h0000, 1, 65};
      // Completion on the last watchdog cycle wins over the abort.
      vecs[7] = '{0, 8'h10, 8'h10, 64, 16'h0100, 0, 65};

      rstn    = 1'b0;
      req_vld = 4'hF;
      req_a   = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b   = {8'd3, 8'd3, 8'd3, 8'd3};
      rsp_rdy = 1'b1;
      core_lat = 2;
      core_en  = 1'b1;
      #3;
      chk("rst_req_rdy", {28'b0, req_rdy}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_mul_vld", {31'b0, mul_vld}, 32'd0);
      chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
      chk("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
      chk("rst_mul_ops", {16'b0, mul_a, mul_b}, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      #1;

      // Contention: everyone requests continuously; grants must rotate 0,1,2,3,0.
      k = 0;
      n = 0;
      while (k < 5 && n < 200) begin
         if (req_rdy != 4'b0) begin
            chk("rr_grant", {28'b0, req_rdy}, 32'(1 << (k % 4)));
            $display("grant %0d req_rdy=%b", k, req_rdy);
            k++;
         end
         if (k < 5) begin
            tick();
            n++;
         end
      end
      chk("rr_count", k, 5);
      tick();
      req_vld = 4'b0;
      #1;
      wait_rsp(lat);
      chk("rr_last_id", {30'b0, rsp_id}, 32'd0);
      chk("rr_last_data", {16'b0, rsp_data}, 32'h0003);
      tick();

      for (int i = 0; i < 8; i++) run_op(vecs[i]);

      // Backpressure: response held 5 cycles while requester 0 waits.
      core_lat = 2;
      core_en  = 1'b1;
      req_a[15:8] = 8'h03;
      req_b[15:8] = 8'h05;
      rsp_rdy = 1'b0;
      req_vld = 4'b0010;
      wait_grant(1);
      tick();
      req_vld = 4'b0001;
      req_a[7:0] = 8'h06;
      req_b[7:0] = 8'hF9;
      #1;
      chk("bp_busy_no_rdy", {28'b0, req_rdy}, 32'd0);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_vld", {31'b0, rsp_vld}, 32'd1);
         chk("bp_rsp_data", {16'b0, rsp_data}, 32'h000F);
         chk("bp_rsp_id", {30'b0, rsp_id}, 32'd1);
         chk("bp_req_rdy", {28'b0, req_rdy}, 32'd0);
         chk("bp_mul_vld", {31'b0, mul_vld}, 32'd0);
         tick();
      end
      rsp_rdy = 1'b1;
      #1;
      chk("bp_hold_until_rdy", {31'b0, rsp_vld}, 32'd1);
      $display("bp op id=1 data=%h released", rsp_data);
      tick();
      chk("bp_next_grant", {28'b0, req_rdy}, 32'b0001);
      chk("bp_rsp_vld_low", {31'b0, rsp_vld}, 32'd0);
      tick();
      req_vld = 4'b0;
      #1;
      wait_rsp(lat);
      chk("bp2_rsp_id", {30'b0, rsp_id}, 32'd0);
      chk("bp2_rsp_data", {16'b0, rsp_data}, 32'hFFD6);
      $display("bp op id=0 data=%h", rsp_data);
      tick();

      // Reset in the middle of an operation.
      core_lat = 20;
      req_a[23:16] = 8'h21;
      req_b[23:16] = 8'h02;
      req_vld = 4'b0100;
      wait_grant(2);
      tick();
      req_vld = 4'b0;
      tick();
      tick();
      chk("mid_busy", {31'b0, busy}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("rst_async_mul_vld", {31'b0, mul_vld}, 32'd0);
      chk("rst_async_busy", {31'b0, busy}, 32'd0);
      chk("rst_async_rsp_vld", {31'b0, rsp_vld}, 32'd0);
      chk("rst_async_rsp_data", {16'b0, rsp_data}, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (rsp_vld) seen = 1'b1;
      end
      chk("rst_discard", {31'b0, seen}, 32'd0);
      core_lat = 2;
      req_vld = 4'hF;
      #1;
      chk("rst_first_grant", {28'b0, req_rdy}, 32'b0001);
      $display("post-reset grant req_rdy=%b", req_rdy);
      tick();
      req_vld = 4'b0;
      #1;
      wait_rsp(lat);
      chk("rst_op_id", {30'b0, rsp_id}, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
